sram_fifo_checked: RTL and testbench

SRAM_FIFO_CHECKED -- requirements
Module: sram_fifo_checked

---
 rtl/sram_fifo_checked_pkg.sv | 11 +
 rtl/sram_fifo_checked_sram_dp.sv | 23 ++
 rtl/sram_fifo_checked.sv | 77 +++++++
 tb/tb_sram_fifo_checked.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/sram_fifo_checked_pkg.sv
// sram_fifo_checked_pkg: shared defaults and pointer sizing for the SRAM-backed FIFO.
package sram_fifo_checked_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH_LOG2 = 3;

    function automatic int ptrWidth(int log2Depth);
        return log2Depth + 1;
    endfunction

endpackage

// File: rtl/sram_fifo_checked_sram_dp.sv
// sram_dp: simple dual-port synchronous RAM with one write port and a registered read port.
module sram_dp #(
    parameter int WIDTH = 8,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

    // Read-before-write when both ports hit the same address.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/sram_fifo_checked.sv
// sram_fifo_checked: synchronous FIFO over a dual-port SRAM with threshold flags and sticky error flags.
module sram_fifo_checked
    import sram_fifo_checked_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
    parameter int AF_LEVEL = (1 << DEPTH_LOG2) - 1,
    parameter int AE_LEVEL = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clear,
    input  logic                             wr_en,
    input  logic [WIDTH-1:0]                 wr_data,
    input  logic                             rd_en,
    output logic [WIDTH-1:0]                 rd_data,
    output logic                             rd_valid,
    output logic                             full,
    output logic                             empty,
    output logic                             almost_full,
    output logic                             almost_empty,
    output logic [ptrWidth(DEPTH_LOG2)-1:0]  count,
    output logic                             overflow,
    output logic                             underflow
);

    localparam int PW = ptrWidth(DEPTH_LOG2);

    logic [PW-1:0]    wrPtr, rdPtr;
    logic [WIDTH-1:0] ramQ, lastData;
    logic             wrAcc, rdAcc;

    assign empty = wrPtr == rdPtr;
    assign full = (wrPtr[PW-1] != rdPtr[PW-1]) && (wrPtr[PW-2:0] == rdPtr[PW-2:0]);
    assign count = wrPtr - rdPtr;
    assign almost_full = int'(count) >= AF_LEVEL;
    assign almost_empty = int'(count) <= AE_LEVEL;
    assign rdAcc = rd_en && !empty && !clear;
    assign wrAcc = wr_en && (!full || rdAcc) && !clear;
    // The RAM output is unreset, so a held copy supplies rd_data between reads.
    assign rd_data = rd_valid ? ramQ : lastData;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            rd_valid <= 1'b0;
            lastData <= '0;
            overflow <= 1'b0;
            underflow <= 1'b0;
        end else if (clear) begin
            wrPtr <= '0;
            rdPtr <= '0;
            rd_valid <= 1'b0;
            overflow <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wrAcc) wrPtr <= wrPtr + PW'(1);
            if (rdAcc) rdPtr <= rdPtr + PW'(1);
            if (rd_valid) lastData <= ramQ;
            rd_valid <= rdAcc;
            overflow <= overflow || (wr_en && full && !rdAcc);
            underflow <= underflow || (rd_en && empty);
        end
    end

    sram_dp #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) uRam (
        .clk   (clk),
        .we    (wrAcc),
        .waddr (wrPtr[PW-2:0]),
        .wdata (wr_data),
        .re    (rdAcc),
        .raddr (rdPtr[PW-2:0]),
        .rdata (ramQ)
    );

endmodule

// File: tb/tb_sram_fifo_checked.sv
// tb_sram_fifo_checked: directed stimulus with immediate assertions for the SRAM FIFO.
module tb_sram_fifo_checked;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clear = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = '0;
    logic       rd_en = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [3:0] count;
    int         checks = 0;
    int         errors = 0;

    sram_fifo_checked dut (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic w, input logic [7:0] d, input logic r);
        wr_en = w;
        wr_data = d;
        rd_en = r;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 16'(count), 0);
        chk("rst_empty", 16'(empty), 1);
        chk("rst_full", 16'(full), 0);
        chk("rst_ae", 16'(almost_empty), 1);
        chk("rst_af", 16'(almost_full), 0);
        chk("rst_valid", 16'(rd_valid), 0);
        chk("rst_data", 16'(rd_data), 0);
        chk("rst_ovf", 16'(overflow), 0);
        chk("rst_unf", 16'(underflow), 0);
        rst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            step(1'b1, 8'(8'h10 + i), 1'b0);
            chk("fill_count", 16'(count), 16'(i + 1));
            chk("fill_af", 16'(almost_full), 16'(i + 1 >= 7));
            chk("fill_ae", 16'(almost_empty), 16'(i + 1 <= 1));
        end
        chk("fill_full", 16'(full), 1);
        chk("fill_empty", 16'(empty), 0);

        step(1'b1, 8'hAA, 1'b0);
        chk("ovf_flag", 16'(overflow), 1);
        chk("ovf_count", 16'(count), 8);
        chk("ovf_unf", 16'(underflow), 0);

        for (int i = 0; i < 8; i++) begin
            step(1'b0, 8'h00, 1'b1);
            chk("drain_valid", 16'(rd_valid), 1);
            chk("drain_data", 16'(rd_data), 16'(8'h10 + i));
        end
        step(1'b0, 8'h00, 1'b0);
        chk("drain_idle_valid", 16'(rd_valid), 0);
        chk("drain_hold_data", 16'(rd_data), 16'h17);
        chk("drain_empty", 16'(empty), 1);
        chk("drain_count", 16'(count), 0);
        chk("ovf_sticky", 16'(overflow), 1);

        step(1'b0, 8'h00, 1'b1);
        chk("unf_flag", 16'(underflow), 1);
        chk("unf_valid", 16'(rd_valid), 0);
        chk("unf_count", 16'(count), 0);
        clear = 1'b1;
        step(1'b1, 8'h99, 1'b1);
        clear = 1'b0;
        chk("clr_unf", 16'(underflow), 0);
        chk("clr_ovf", 16'(overflow), 0);
        chk("clr_count", 16'(count), 0);
        chk("clr_valid", 16'(rd_valid), 0);

        step(1'b1, 8'h55, 1'b1);
        chk("sim_empty_count", 16'(count), 1);
        chk("sim_empty_valid", 16'(rd_valid), 0);
        step(1'b0, 8'h00, 1'b1);
        chk("sim_empty_rd_valid", 16'(rd_valid), 1);
        chk("sim_empty_rd_data", 16'(rd_data), 16'h55);
        chk("sim_empty_after", 16'(count), 0);

        for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h20 + i), 1'b0);
        chk("sim_full_pre", 16'(full), 1);
        step(1'b1, 8'h30, 1'b1);
        chk("sim_full_count", 16'(count), 8);
        chk("sim_full_data", 16'(rd_data), 16'h20);
        chk("sim_full_ovf", 16'(overflow), 0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 8'h00, 1'b1);
            chk("sim_full_drain", 16'(rd_data), (i < 7) ? 16'(8'h21 + i) : 16'h30);
        end
        chk("sim_full_empty", 16'(empty), 1);

        step(1'b1, 8'h00, 1'b0);
        for (int i = 1; i < 20; i++) begin
            step(1'b1, 8'(i), 1'b0);
            chk("wrap_count2", 16'(count), 2);
            chk("wrap_ae_off", 16'(almost_empty), 0);
            step(1'b0, 8'h00, 1'b1);
            chk("wrap_data", 16'(rd_data), 16'(i - 1));
            chk("wrap_count1", 16'(count), 1);
            chk("wrap_ae_on", 16'(almost_empty), 1);
        end
        step(1'b0, 8'h00, 1'b1);
        chk("wrap_last", 16'(rd_data), 16'h13);
        chk("wrap_empty", 16'(empty), 1);

        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
        chk("mid_pre_count", 16'(count), 5);
        rd_en = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        chk("mid_count", 16'(count), 0);
        chk("mid_empty", 16'(empty), 1);
        chk("mid_valid", 16'(rd_valid), 0);
        chk("mid_data", 16'(rd_data), 0);
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h00, 1'b0);
            chk("mid_post_valid", 16'(rd_valid), 0);
            chk("mid_post_count", 16'(count), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
